// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle control around a combinational signed divider with two-beat HI/LO writeback
module div_sequencer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [WIDTH-1:0]   div_a,
  output logic [WIDTH-1:0]   div_b,
  input  logic [2*WIDTH-1:0] div_z,
  output logic [WIDTH-1:0]   bus_out,
  output logic               lo_en,
  output logic               hi_en,
  output logic               busy,
  output logic               done,
  output logic               dz_err
);
  typedef enum logic [2:0] {IDLE, SETTLE, WR_LO, WR_HI, DONE} state_t;
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  state_t             r_state;
  logic [3:0]         r_cnt;
  logic               r_dz;
  logic [WIDTH-1:0]   r_div_a, r_div_b;
  logic [2*WIDTH-1:0] r_res;
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
      r_div_a <= '0;
      r_div_b <= '0;
      r_res   <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_div_a <= a_in;
          r_div_b <= b_in;
          r_dz    <= (b_in == '0);
          r_cnt   <= CNT_INIT;
          r_state <= SETTLE;
        end
        SETTLE: if (r_cnt == '0) begin
          r_res   <= div_z;
          r_state <= r_dz ? DONE : WR_LO;
        end else r_cnt <= r_cnt - 4'd1;
        WR_LO:   r_state <= WR_HI;
        WR_HI:   r_state <= DONE;
        default: r_state <= IDLE;
      endcase
    end
  end
  // every output is a pure decode of registered state/data, so start never reaches an output combinationally
  always_comb begin
    busy    = r_state != IDLE;
    lo_en   = r_state == WR_LO;
    hi_en   = r_state == WR_HI;
    done    = r_state == DONE;
    dz_err  = (r_state == DONE) && r_dz;
    bus_out = (r_state == WR_LO) ? r_res[WIDTH-1:0] : (r_state == WR_HI) ? r_res[2*WIDTH-1:WIDTH] : '0;
    div_a   = r_div_a;
    div_b   = r_div_b;
  end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: randomized self-checking bench for div_sequencer at SETTLE_CYCLES=1 and 3
module tb_div_sequencer;
  logic        clk = 1'b0;
  logic        clr, start1, start3, corrupt;
  logic [31:0] a_in, b_in;
  logic [31:0] da1, db1, bus1, da3, db3, bus3;
  logic [63:0] z1, z3;
  logic        lo1, hi1, busy1, done1, dz1;
  logic        lo3, hi3, busy3, done3, dz3;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // behavioural divider: truncating quotient, remainder follows the dividend
  function automatic logic [63:0] divm(logic [31:0] a, logic [31:0] b);
    longint la, lb, q, r;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    if (lb == 0) return 64'hDEADBEEF_0BADF00D;
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // expected {bus, lo_en, hi_en, busy, done, dz_err} in cycle k after start sampled at edge 0
  function automatic logic [36:0] expv(logic [31:0] a, logic [31:0] b, int s, int k);
    logic [63:0] z;
    logic [31:0] bus;
    logic        lo, hi, dz;
    int          dc;
    z   = divm(a, b);
    dz  = (b == 0);
    dc  = dz ? s + 1 : s + 3;
    lo  = !dz && k == s + 1;
    hi  = !dz && k == s + 2;
    bus = lo ? z[31:0] : hi ? z[63:32] : 32'h0;
    return {bus, lo, hi, k >= 1 && k <= dc, k == dc, k == dc && dz};
  endfunction

  function automatic logic [36:0] obs(int sel);
    return (sel == 3) ? {bus3, lo3, hi3, busy3, done3, dz3} : {bus1, lo1, hi1, busy1, done1, dz1};
  endfunction

  function automatic logic [63:0] obs_ab(int sel);
    return (sel == 3) ? {da3, db3} : {da1, db1};
  endfunction

  function automatic logic [31:0] rand_b();
    int r;
    r = $urandom_range(0, 3);
    return (r == 0) ? 32'h0 : (r == 1) ? 32'($urandom_range(1, 20)) : (r == 2) ? -32'($urandom_range(1, 20)) : $urandom;
  endfunction

  assign z1 = divm(da1, db1);
  assign z3 = corrupt ? ~divm(da3, db3) : divm(da3, db3);

  div_sequencer #(.WIDTH(32), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .clr(clr), .start(start1), .a_in(a_in), .b_in(b_in),
    .div_a(da1), .div_b(db1), .div_z(z1), .bus_out(bus1),
    .lo_en(lo1), .hi_en(hi1), .busy(busy1), .done(done1), .dz_err(dz1)
  );

  div_sequencer #(.WIDTH(32), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .clr(clr), .start(start3), .a_in(a_in), .b_in(b_in),
    .div_a(da3), .div_b(db3), .div_z(z3), .bus_out(bus3),
    .lo_en(lo3), .hi_en(hi3), .busy(busy3), .done(done3), .dz_err(dz3)
  );

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (obs(1) !== 37'h0 || obs(3) !== 37'h0) begin
      errors++;
      $display("FAIL reset outputs: got %h / %h expected 0", obs(1), obs(3));
    end
    checks++;
    if ({obs_ab(1), obs_ab(3)} !== 128'h0) begin
      errors++;
      $display("FAIL reset operands: got %h %h expected 0", obs_ab(1), obs_ab(3));
    end
    clr = 1'b0;
  endtask

  // one operation; inputs are scrambled after start to prove they are sampled only once
  task automatic test_op(input int sel, input logic [31:0] a, input logic [31:0] b, input string name);
    a_in = a;
    b_in = b;
    if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
    for (int k = 1; k <= sel + 4; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      start3 = 1'b0;
      a_in   = $urandom;
      b_in   = $urandom;
      checks++;
      if (obs(sel) !== expv(a, b, sel, k)) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs(sel), expv(a, b, sel, k));
      end
      checks++;
      if (obs_ab(sel) !== {a, b}) begin
        errors++;
        $display("FAIL %s operands cycle %0d: got %h expected %h", name, k, obs_ab(sel), {a, b});
      end
    end
  endtask

  task automatic test_signed();
    test_op(1, 32'd100, 32'd7, "basic_100_7");
    test_op(1, -32'd100, 32'd7, "neg_dividend");
    test_op(1, 32'd100, -32'd7, "neg_divisor");
    test_op(1, -32'd100, -32'd7, "both_neg");
    test_op(1, 32'h8000_0000, 32'hFFFF_FFFF, "overflow");
  endtask

  task automatic test_div_zero();
    test_op(1, 32'd55, 32'd0, "div_zero");
    test_op(3, 32'hFFFF_FF00, 32'd0, "div_zero_s3");
  endtask

  task automatic test_ignore_start();
    logic [36:0] e;
    logic [31:0] ea;
    a_in   = 32'd100;
    b_in   = 32'd7;
    start1 = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start1 = (k == 1 || k == 4 || k == 5);
      a_in   = start1 ? 32'd9 : $urandom;
      b_in   = start1 ? 32'd2 : $urandom;
      e      = (k <= 5) ? expv(32'd100, 32'd7, 1, k) : expv(32'd9, 32'd2, 1, k - 5);
      ea     = (k <= 5) ? 32'd100 : 32'd9;
      checks++;
      if (obs(1) !== e) begin
        errors++;
        $display("FAIL ignore_start cycle %0d: got %h expected %h", k, obs(1), e);
      end
      checks++;
      if (da1 !== ea) begin
        errors++;
        $display("FAIL ignore_start div_a cycle %0d: got %h expected %h", k, da1, ea);
      end
    end
    start1 = 1'b0;
  endtask

  task automatic test_clr_abort();
    logic [36:0] e;
    a_in   = 32'd100;
    b_in   = 32'd7;
    start1 = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start1 = 1'b0;
      e      = (k <= 2) ? expv(32'd100, 32'd7, 1, k) : 37'h0;
      checks++;
      if (obs(1) !== e) begin
        errors++;
        $display("FAIL clr_abort cycle %0d: got %h expected %h", k, obs(1), e);
      end
      if (k >= 3) begin
        checks++;
        if (obs_ab(1) !== 64'h0) begin
          errors++;
          $display("FAIL clr_abort operands cycle %0d: got %h expected 0", k, obs_ab(1));
        end
      end
      clr = (k == 2);
    end
    clr = 1'b0;
  endtask

  // divider output is wrong except in the final settle cycle, so only a correctly timed capture sees 30 r 10
  task automatic test_settle3();
    a_in    = 32'd1000;
    b_in    = 32'd33;
    start3  = 1'b1;
    corrupt = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      start3  = 1'b0;
      corrupt = (k != 3);
      checks++;
      if (obs(3) !== expv(32'd1000, 32'd33, 3, k)) begin
        errors++;
        $display("FAIL settle3 cycle %0d: got %h expected %h", k, obs(3), expv(32'd1000, 32'd33, 3, k));
      end
    end
    corrupt = 1'b0;
  endtask

  // start held high: each new op is accepted in the first IDLE cycle after the previous one
  task automatic test_back_to_back(input int sel, input int n);
    logic [31:0] a, b, na, nb;
    int          per;
    a    = $urandom;
    b    = rand_b();
    a_in = a;
    b_in = b;
    if (sel == 3) start3 = 1'b1; else start1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      per = (b == 0) ? sel + 2 : sel + 4;
      na  = $urandom;
      nb  = rand_b();
      for (int k = 1; k <= per; k++) begin
        @(negedge clk);
        a_in = (k == per) ? na : $urandom;
        b_in = (k == per) ? nb : $urandom;
        if (k == per && i == n - 1) begin
          start1 = 1'b0;
          start3 = 1'b0;
        end
        checks++;
        if (obs(sel) !== expv(a, b, sel, k)) begin
          errors++;
          $display("FAIL b2b s%0d op %0d (%h/%h) cycle %0d: got %h expected %h", sel, i, a, b, k, obs(sel), expv(a, b, sel, k));
        end
        checks++;
        if (obs_ab(sel) !== {a, b}) begin
          errors++;
          $display("FAIL b2b s%0d op %0d operands cycle %0d: got %h expected %h", sel, i, k, obs_ab(sel), {a, b});
        end
      end
      a = na;
      b = nb;
    end
  endtask

  initial begin
    clr     = 1'b1;
    start1  = 1'b0;
    start3  = 1'b0;
    corrupt = 1'b0;
    a_in    = '0;
    b_in    = '0;
    test_reset();
    test_signed();
    test_div_zero();
    test_ignore_start();
    test_clr_abort();
    test_settle3();
    test_back_to_back(1, 30);
    test_back_to_back(3, 12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle control stage wrapped around the combinational signed 32-bit divider. It registers the dividend and divisor and drives them into the divider. After a fixed settle time it captures the divider's 64-bit result {remainder, quotient}. It then writes the result onto the 32-bit datapath bus in two beats, quotient into LO and remainder into HI, matching the DIV instruction's T5/T6 writeback. It also flags divide-by-zero and suppresses the HI/LO writes in that case.

Parameters:
WIDTH, 32, operand width; the divider result is 2*WIDTH.
SETTLE_CYCLES, 1, cycles the divider inputs are held before the result is captured (range 1..15).

Ports:
clk  in  1  rising-edge clock
clr  in  1  synchronous active-high reset
start  in  1  request a division; sampled only in IDLE
a_in  in  WIDTH  signed dividend; sampled with start
b_in  in  WIDTH  signed divisor; sampled with start
div_a  out  WIDTH  registered dividend, drives divider A
div_b  out  WIDTH  registered divisor, drives divider B
div_z  in  2*WIDTH  divider result: [2W-1:W] remainder, [W-1:0] quotient
bus_out  out  WIDTH  writeback data to the bus
lo_en  out  1  LO register write enable
hi_en  out  1  HI register write enable
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
dz_err  out  1  high with done when the divisor was zero

Behaviour:
- Reset: clr high at a clock edge forces state IDLE, settle counter 0, div_a/div_b/result register 0, bus_out 0, and lo_en/hi_en/done/dz_err/busy 0. clr overrides start and aborts any operation, including mid-writeback; no further enables are issued.
- States: IDLE, SETTLE, WR_LO, WR_HI, DONE. All outputs are decoded from registered state and data, with no combinational path from start.
- IDLE: when start=1, latch a_in->div_a, b_in->div_b, and dz_flag=(b_in==0). Load counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE: if counter==0, capture div_z into the result register, then go to DONE if dz_flag is set, else go to WR_LO. Otherwise decrement the counter.
- WR_LO: bus_out=result[W-1:0] (quotient) and lo_en=1 for exactly one cycle, then go to WR_HI.
- WR_HI: bus_out=result[2W-1:W] (remainder) and hi_en=1 for exactly one cycle, then go to DONE.
- DONE: done=1 for one cycle and dz_err=dz_flag, then go to IDLE.
- bus_out is 0 outside WR_LO/WR_HI. lo_en and hi_en are never high together and are never asserted on a dz path.
- start is ignored while busy, including during DONE; it is not queued. A new start is accepted in the first IDLE cycle after DONE, so back-to-back throughput is one op per 4+SETTLE_CYCLES cycles.
- Latency (start sampled at edge 0):
  - WR_LO occurs in cycle SETTLE_CYCLES+1.
  - WR_HI occurs in cycle SETTLE_CYCLES+2.
  - done occurs in cycle SETTLE_CYCLES+3.
  - dz path: done occurs in cycle SETTLE_CYCLES+1.
- div_a and div_b hold their values from start until the next accepted start; they are not cleared in DONE.
- Arithmetic is the divider's: truncating quotient, remainder takes the sign of the dividend. This block never modifies the result bits.
- Overflow case -2^31 / -1 is not flagged; whatever div_z yields is written as-is.

Test Plan:
- a=100, b=7, SETTLE=1 -> cycle 2: lo_en, bus=0x0000000E; cycle 3: hi_en, bus=0x00000002; cycle 4: done=1, dz_err=0.
- a=-100, b=7 -> LO=0xFFFFFFF2 (-14), HI=0xFFFFFFFE (-2); a=100, b=-7 -> LO=0xFFFFFFF2, HI=0x00000002.
- a=55, b=0 -> no lo_en/hi_en ever; done=1 and dz_err=1 in cycle 2; busy drops in cycle 3.
- Start pulse with a=9, b=2 during SETTLE and again during DONE of the op 100/7 -> both ignored; exactly one LO/HI pair (14, 2) written. A start in the following IDLE cycle is accepted.
- clr asserted during WR_LO -> next cycle IDLE, hi_en never asserted, all outputs 0, done never pulses.
- SETTLE_CYCLES=3 with a=1000, b=33 -> lo_en in cycle 4 with 0x1E, hi_en in cycle 5 with 0x0A, done in cycle 6. div_z is captured only at the end of SETTLE (the bench changes the model output mid-settle to prove this).
